// File: rtl/mux2_hpc1_sched.sv
// Round-robin scheduler time-sharing one masked mux2 gadget among n_req requesters.
// Gates issue on PRNG availability and tags each gadget result with its requester id.
module mux2_hpc1_sched #(
    parameter int security_order = 2,
    parameter int n_req          = 4,
    parameter int id_w           = 2,
    parameter int gadget_lat     = 2,
    localparam int d             = security_order + 1,
    localparam int cnt_w         = $clog2(gadget_lat + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [n_req-1:0]     req,
    output logic [n_req-1:0]     gnt,
    input  logic [n_req*d-1:0]   req_a,
    input  logic [n_req*d-1:0]   req_b,
    input  logic [n_req*d-1:0]   req_s,
    input  logic                 rnd_valid,
    output logic                 rnd_ack,
    output logic [d-1:0]         g_ina,
    output logic [d-1:0]         g_inb,
    output logic [d-1:0]         g_ins,
    input  logic [d-1:0]         g_out,
    output logic                 out_valid,
    output logic [id_w-1:0]      out_id,
    output logic [d-1:0]         out_data,
    output logic [cnt_w-1:0]     inflight
);

    logic [id_w-1:0]       ptr_q, ptr_d;
    logic [id_w-1:0]       winner;
    logic                  found;
    logic                  issue;
    int                    scan_idx;
    logic [gadget_lat-1:0] vld_q;
    logic [id_w-1:0]       id_q [gadget_lat];
    logic [cnt_w-1:0]      inflight_cnt;

    // Scan from the priority pointer, wrapping at n_req (not at 2**id_w).
    always_comb begin
        found    = 1'b0;
        winner   = ptr_q;
        scan_idx = 0;
        for (int k = 0; k < n_req; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= n_req) begin
                scan_idx = scan_idx - n_req;
            end
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx[id_w-1:0];
            end
        end
    end

    assign issue   = rnd_valid & (|req) & ~rst;
    assign rnd_ack = issue;

    for (genvar gi = 0; gi < n_req; gi++) begin : g_gnt
        assign gnt[gi] = issue && (winner == id_w'(gi));
    end

    // Share k of the granted slice only ever feeds share k of the gadget.
    for (genvar gi = 0; gi < d; gi++) begin : g_share
        logic [n_req-1:0] a_col, b_col, s_col;
        for (genvar gj = 0; gj < n_req; gj++) begin : g_col
            assign a_col[gj] = req_a[gj*d + gi];
            assign b_col[gj] = req_b[gj*d + gi];
            assign s_col[gj] = req_s[gj*d + gi];
        end
        assign g_ina[gi] = |(gnt & a_col);
        assign g_inb[gi] = |(gnt & b_col);
        assign g_ins[gi] = |(gnt & s_col);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (winner == id_w'(n_req - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < gadget_lat; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            vld_q[0] <= issue;
            id_q[0]  <= winner;
            for (int i = 1; i < gadget_lat; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < gadget_lat; i++) begin
            inflight_cnt = inflight_cnt + cnt_w'(vld_q[i]);
        end
    end

    assign inflight  = inflight_cnt;
    assign out_valid = vld_q[gadget_lat-1];
    assign out_id    = id_q[gadget_lat-1];
    assign out_data  = g_out;

endmodule
